uart_rx_param: RTL



---
 rtl/uart_rx_param.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits,
// with valid strobe and parity/framing flags. Define UART_RX_MAJORITY_EN for 3-sample majority voting.
module uart_rx_param #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int MID          = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W        = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = ($clog2(DATA_BITS) < 1) ? 1 : $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(MID + 1);
`else
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(MID);
`endif
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic bad;
        if (PARITY == 1) begin
            bad = ~(^d ^ p);
        end else if (PARITY == 2) begin
            bad = ^d ^ p;
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t               state_q;
    logic                 sync1_q;
    logic                 sync_in_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bad_q;
    logic                 stop_bad_q;
    logic                 armed_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 rx_busy_q;
    logic                 sample_tick_s;
    logic                 baud_tick_s;
    logic                 bit_s;

`ifndef SYNTHESIS
    initial begin
        if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin
            $error("uart_rx_param: illegal parameters (CLKS_PER_BIT=%0d DATA_BITS=%0d PARITY=%0d STOP_BITS=%0d)",
                   CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS);
        end
    end
`endif

    // Two-flop synchronizer; idles high so reset does not fake a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync_in_q <= 1'b1;
        end else begin
            sync1_q   <= data_in;
            sync_in_q <= sync1_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic maj0_q;
    logic maj1_q;

    // Capture the two early votes; the third is the live sample at MID+1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj0_q <= 1'b1;
            maj1_q <= 1'b1;
        end else begin
            if (cnt_q == CNT_W'(MID - 1)) begin
                maj0_q <= sync_in_q;
            end
            if (cnt_q == CNT_W'(MID)) begin
                maj1_q <= sync_in_q;
            end
        end
    end
`endif

    // Tick decode and the bit value used at each sample point
    always_comb begin
        sample_tick_s = (cnt_q == SAMPLE_AT);
        baud_tick_s   = (cnt_q == CNT_LAST);
`ifdef UART_RX_MAJORITY_EN
        bit_s         = majority3(maj0_q, maj1_q, sync_in_q);
`else
        bit_s         = sync_in_q;
`endif
    end

    // Receive FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            armed_q      <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q      <= '0;
                    bit_idx_q  <= '0;
                    stop_idx_q <= 1'b0;
                    // After a break the line must be seen high before a new start counts
                    if (!armed_q) begin
                        armed_q <= sync_in_q;
                    end else if (!sync_in_q) begin
                        state_q    <= S_START;
                        rx_busy_q  <= 1'b1;
                        par_bad_q  <= 1'b0;
                        stop_bad_q <= 1'b0;
                    end
                end
                S_START: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (sample_tick_s && bit_s) begin
                        state_q   <= S_IDLE;
                        rx_busy_q <= 1'b0;
                        cnt_q     <= '0;
                    end else if (baud_tick_s) begin
                        state_q <= S_DATA;
                        cnt_q   <= '0;
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // LSB arrives first, so shifting in at the top leaves it at bit 0
                    if (sample_tick_s) begin
                        shift_q <= {bit_s, shift_q[DATA_BITS-1:1]};
                    end
                    if (baud_tick_s) begin
                        cnt_q <= '0;
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (sample_tick_s) begin
                        par_bad_q <= parity_bad(shift_q, bit_s);
                    end
                    if (baud_tick_s) begin
                        state_q <= S_STOP;
                        cnt_q   <= '0;
                    end
                end
                S_STOP: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (sample_tick_s) begin
                        if (stop_idx_q == LAST_STOP) begin
                            // Finish at mid-stop so a back-to-back start edge is not missed
                            rx_data_q    <= shift_q;
                            rx_valid_q   <= 1'b1;
                            parity_err_q <= par_bad_q;
                            frame_err_q  <= stop_bad_q | ~bit_s;
                            state_q      <= S_IDLE;
                            rx_busy_q    <= 1'b0;
                            cnt_q        <= '0;
                            armed_q      <= bit_s;
                        end else begin
                            stop_bad_q <= stop_bad_q | ~bit_s;
                        end
                    end else if (baud_tick_s) begin
                        stop_idx_q <= ~stop_idx_q;
                        cnt_q      <= '0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    rx_busy_q <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = rx_busy_q;

endmodule
